// File: rtl/out_port_sched.sv
// Output-port packet scheduler: strict-priority or weighted-round-robin selection
// among NUM_PRI head packets, then a burst read of the chosen packet from the buffer.
module out_port_sched #(
  parameter int NUM_PRI      = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 12,
  parameter int LEN_WIDTH    = 7,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sp0_wrr1,
  input  logic [NUM_PRI-1:0]               prepared,
  input  logic [NUM_PRI-1:0]               ready,
  input  logic [NUM_PRI*WEIGHT_WIDTH-1:0]  wrr_weight,
  input  logic [NUM_PRI*ADDR_WIDTH-1:0]    head_addr,
  input  logic [NUM_PRI*LEN_WIDTH-1:0]     head_len,
  output logic [NUM_PRI-1:0]               pop,
  output logic                             rd_request,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0]            data_read,
  output logic                             rd_sop,
  output logic                             rd_eop,
  output logic                             rd_vld,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             busy
);

  localparam int PTR_W = (NUM_PRI > 1) ? $clog2(NUM_PRI) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic                    first_q, first_d;
  logic                    rd_vld_q, rd_sop_q, rd_eop_q;

  logic [NUM_PRI-1:0]      eligible_s;
  logic [NUM_PRI-1:0]      pop_s;
  logic [PTR_W-1:0]        sp_sel_s, wrr_sel_s, cand_s, grant_s, wrr_ptr_s;
  logic [WEIGHT_WIDTH:0]   wrr_cred_s, wght_s;
  logic [LEN_WIDTH-1:0]    len_s;

  // Sum of a pointer and an offset (both below NUM_PRI), folded back into 0..NUM_PRI-1.
  function automatic logic [PTR_W-1:0] ptr_wrap(input logic [PTR_W:0] sum);
    logic [PTR_W:0] r;
    r = (sum >= (PTR_W+1)'(NUM_PRI)) ? (sum - (PTR_W+1)'(NUM_PRI)) : sum;
    return r[PTR_W-1:0];
  endfunction

  // A zero weight still earns one grant per round so no queue can be starved.
  function automatic logic [WEIGHT_WIDTH:0] eff_weight(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == {WEIGHT_WIDTH{1'b0}}) ? {{WEIGHT_WIDTH{1'b0}}, 1'b1} : {1'b0, w};
  endfunction

  assign eligible_s = prepared & ready;

  // Candidate selection: lowest eligible index, and first eligible at/after the WRR pointer.
  always_comb begin
    sp_sel_s  = {PTR_W{1'b0}};
    wrr_sel_s = ptr_q;
    cand_s    = ptr_q;
    for (int i = NUM_PRI - 1; i >= 0; i--) begin
      sp_sel_s  = eligible_s[i] ? PTR_W'(i) : sp_sel_s;
      cand_s    = ptr_wrap({1'b0, ptr_q} + (PTR_W+1)'(i));
      wrr_sel_s = eligible_s[cand_s] ? cand_s : wrr_sel_s;
    end
  end

  // Next-state logic: grant and pointer/credit bookkeeping in IDLE, word sequencing in READ.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    first_d    = first_q;
    pop_s      = {NUM_PRI{1'b0}};
    grant_s    = sp_sel_s;
    len_s      = {LEN_WIDTH{1'b0}};
    wrr_ptr_s  = ptr_q;
    wrr_cred_s = {1'b0, credit_q};
    wght_s     = {{WEIGHT_WIDTH{1'b0}}, 1'b1};
    case (state_q)
      IDLE: begin
        grant_s = sp0_wrr1 ? wrr_sel_s : sp_sel_s;
        if (|eligible_s) begin
          pop_s[grant_s] = 1'b1;
          addr_d  = head_addr[grant_s*ADDR_WIDTH +: ADDR_WIDTH];
          len_s   = head_len[grant_s*LEN_WIDTH +: LEN_WIDTH];
          // rem counts words still to issue after the current one; length 0 reads one word.
          rem_d   = (len_s == {LEN_WIDTH{1'b0}}) ? {LEN_WIDTH{1'b0}} : (len_s - LEN_WIDTH'(1));
          first_d = 1'b1;
          state_d = READ;
          if (sp0_wrr1) begin
            if (grant_s == ptr_q) begin
              wrr_ptr_s  = ptr_q;
              wrr_cred_s = {1'b0, credit_q} + {{WEIGHT_WIDTH{1'b0}}, 1'b1};
            end else begin
              wrr_ptr_s  = grant_s;
              wrr_cred_s = {{WEIGHT_WIDTH{1'b0}}, 1'b1};
            end
            wght_s = eff_weight(wrr_weight[wrr_ptr_s*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            if (wrr_cred_s >= wght_s) begin
              ptr_d    = ptr_wrap({1'b0, wrr_ptr_s} + {{PTR_W{1'b0}}, 1'b1});
              credit_d = {WEIGHT_WIDTH{1'b0}};
            end else begin
              ptr_d    = wrr_ptr_s;
              credit_d = wrr_cred_s[WEIGHT_WIDTH-1:0];
            end
          end else begin
            ptr_d    = ptr_q;
            credit_d = credit_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        first_d = 1'b0;
        if (rem_q == {LEN_WIDTH{1'b0}}) begin
          state_d = IDLE;
        end else begin
          rem_d  = rem_q - LEN_WIDTH'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output-framing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= {PTR_W{1'b0}};
      credit_q <= {WEIGHT_WIDTH{1'b0}};
      addr_q   <= {ADDR_WIDTH{1'b0}};
      rem_q    <= {LEN_WIDTH{1'b0}};
      first_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_sop_q <= 1'b0;
      rd_eop_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      rd_vld_q <= (state_q == READ);
      rd_sop_q <= (state_q == READ) && first_q;
      rd_eop_q <= (state_q == READ) && (rem_q == {LEN_WIDTH{1'b0}});
    end
  end

  assign pop        = rst ? {NUM_PRI{1'b0}} : pop_s;
  assign rd_request = (state_q == READ);
  assign busy       = (state_q != IDLE);
  assign rd_addr    = addr_q;
  assign rd_vld     = rd_vld_q;
  assign rd_sop     = rd_sop_q;
  assign rd_eop     = rd_eop_q;
  // The buffer's read port is already registered; forward its word aligned with rd_vld.
  assign rd_data    = rd_vld_q ? data_read : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_out_port_sched.sv
// Directed bench for out_port_sched: vector table of single-packet grants plus
// hand sequences for backpressure and mid-packet reset.
module tb_out_port_sched;

  localparam int NP = 8;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int LW = 7;
  localparam int WW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              sp0_wrr1;
  logic [NP-1:0]     prepared, ready;
  logic [NP*WW-1:0]  wrr_weight;
  logic [NP*AW-1:0]  head_addr;
  logic [NP*LW-1:0]  head_len;
  logic [NP-1:0]     pop;
  logic              rd_request;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     data_read;
  logic              rd_sop, rd_eop, rd_vld;
  logic [DW-1:0]     rd_data;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        mode;
    logic [7:0]  prep;
    logic [7:0]  rdy;
    logic [31:0] wts;
    logic [6:0]  len;
    logic [11:0] base;
    int          exp_q;
    int          exp_l;
  } vec_t;

  vec_t vecs[$];

  out_port_sched #(
    .NUM_PRI(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .WEIGHT_WIDTH(WW)
  ) dut (
    .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .prepared(prepared), .ready(ready),
    .wrr_weight(wrr_weight), .head_addr(head_addr), .head_len(head_len), .pop(pop),
    .rd_request(rd_request), .rd_addr(rd_addr), .data_read(data_read), .rd_sop(rd_sop),
    .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_of(input logic [11:0] a);
    return {20'hC0FFE, a, 20'h5A5A5, a};
  endfunction

  // Buffer model: synchronous read, word appears the cycle after rd_request.
  always @(posedge clk) data_read <= rd_request ? word_of(rd_addr) : 64'h0BAD_0BAD_0BAD_0BAD;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mode, input logic [7:0] prep, input logic [7:0] rdy,
                       input logic [31:0] wts, input logic [6:0] len, input logic [11:0] base);
    sp0_wrr1   = mode;
    prepared   = prep;
    ready      = rdy;
    wrr_weight = wts;
    for (int i = 0; i < NP; i++) begin
      head_addr[i*AW +: AW] = base + 12'(i * 256);
      head_len[i*LW +: LW]  = len;
    end
  endtask

  function automatic void add_vec(input logic mode, input logic [7:0] prep, input logic [7:0] rdy,
                                  input logic [31:0] wts, input logic [6:0] len,
                                  input logic [11:0] base, input int q, input int l);
    vec_t v;
    v.mode = mode; v.prep = prep; v.rdy = rdy; v.wts = wts; v.len = len;
    v.base = base; v.exp_q = q; v.exp_l = l;
    vecs.push_back(v);
  endfunction

  // Called in the grant cycle (inputs already applied); checks the grant and the whole packet.
  task automatic run_pkt(input int q, input logic [11:0] a0, input int l, input logic [7:0] mid_rdy);
    logic [7:0]  exp_pop;
    logic [11:0] wa;
    exp_pop = (q < 0) ? 8'h00 : (8'h01 << q);
    chk("grant_pop", pop, exp_pop);
    chk("grant_busy", busy, 1'b0);
    if (q < 0) begin
      @(posedge clk); #1;
      chk("nogrant_pop", pop, 8'h00);
      chk("nogrant_busy", busy, 1'b0);
    end else begin
      for (int c = 1; c <= l + 1; c++) begin
        @(posedge clk); #1;
        chk("rd_request", rd_request, (c <= l));
        chk("busy", busy, (c <= l));
        if (c <= l) begin
          wa = a0 + 12'(c - 1);
          chk("rd_addr", rd_addr, wa);
          chk("pop_in_read", pop, 8'h00);
        end
        chk("rd_vld", rd_vld, (c >= 2));
        chk("rd_sop", rd_sop, (c == 2));
        chk("rd_eop", rd_eop, (c == l + 1));
        if (c >= 2) begin
          wa = a0 + 12'(c - 2);
          chk("rd_data", rd_data, word_of(wa));
        end
        if (c == 1) ready = mid_rdy;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    data_read = 64'h0;
    drive(1'b0, 8'hFF, 8'hFF, 32'h1111_1111, 7'd1, 12'h000);

    @(posedge clk); #1;
    chk("rst_pop", pop, 8'h00);
    chk("rst_rd_request", rd_request, 1'b0);
    chk("rst_rd_addr", rd_addr, 12'h000);
    chk("rst_rd_sop", rd_sop, 1'b0);
    chk("rst_rd_eop", rd_eop, 1'b0);
    chk("rst_rd_vld", rd_vld, 1'b0);
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_pop", pop, 8'h00);
    rst = 1'b0;
    prepared = 8'h00;

    // Strict priority, idle cases, WRR order, mode retention, wrap, length 0, max length.
    add_vec(1'b0, 8'h84, 8'hFF, 32'h1111_1111, 7'd2, 12'h010, 2, 2);
    add_vec(1'b0, 8'hFF, 8'hFE, 32'h1111_1111, 7'd3, 12'h020, 1, 3);
    add_vec(1'b0, 8'hA0, 8'hFF, 32'h1111_1111, 7'd1, 12'h030, 5, 1);
    add_vec(1'b0, 8'h00, 8'hFF, 32'h1111_1111, 7'd1, 12'h030, -1, 0);
    add_vec(1'b0, 8'hFF, 8'h00, 32'h1111_1111, 7'd1, 12'h030, -1, 0);
    add_vec(1'b1, 8'h0B, 8'hFF, 32'h1111_0112, 7'd1, 12'h040, 0, 1);
    add_vec(1'b1, 8'h0B, 8'hFF, 32'h1111_0112, 7'd1, 12'h040, 0, 1);
    add_vec(1'b1, 8'h0B, 8'hFF, 32'h1111_0112, 7'd1, 12'h040, 1, 1);
    add_vec(1'b1, 8'h0B, 8'hFF, 32'h1111_0112, 7'd1, 12'h040, 3, 1);
    add_vec(1'b1, 8'h0B, 8'hFF, 32'h1111_0112, 7'd1, 12'h040, 0, 1);
    add_vec(1'b1, 8'h0B, 8'hFF, 32'h1111_0112, 7'd1, 12'h040, 0, 1);
    add_vec(1'b1, 8'h0B, 8'hFF, 32'h1111_0112, 7'd1, 12'h040, 1, 1);
    add_vec(1'b1, 8'h0B, 8'hFF, 32'h1111_0112, 7'd1, 12'h040, 3, 1);
    add_vec(1'b0, 8'h04, 8'hFF, 32'h1111_0112, 7'd1, 12'h050, 2, 1);
    add_vec(1'b1, 8'h09, 8'hFF, 32'h1111_0112, 7'd1, 12'h060, 0, 1);
    add_vec(1'b1, 8'h09, 8'hFF, 32'h1111_0112, 7'd1, 12'h060, 0, 1);
    add_vec(1'b1, 8'h09, 8'hFF, 32'h1111_0112, 7'd1, 12'h060, 3, 1);
    add_vec(1'b0, 8'h01, 8'hFF, 32'h1111_1111, 7'd4, 12'hFFE, 0, 4);
    add_vec(1'b0, 8'h01, 8'hFF, 32'h1111_1111, 7'd0, 12'h100, 0, 1);
    add_vec(1'b0, 8'h01, 8'hFF, 32'h1111_1111, 7'd0, 12'h100, 0, 1);
    add_vec(1'b0, 8'h01, 8'hFF, 32'h1111_1111, 7'd0, 12'h100, 0, 1);
    add_vec(1'b0, 8'h80, 8'hFF, 32'h1111_1111, 7'h7F, 12'h200, 7, 127);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mode, vecs[i].prep, vecs[i].rdy, vecs[i].wts, vecs[i].len, vecs[i].base);
      #1;
      run_pkt(vecs[i].exp_q, vecs[i].base + 12'(vecs[i].exp_q * 256), vecs[i].exp_l, vecs[i].rdy);
    end

    // Backpressure: ready[1] drops right after the grant; packet still completes, no regrant.
    drive(1'b0, 8'h02, 8'hFF, 32'h1111_1111, 7'd5, 12'h300);
    #1;
    run_pkt(1, 12'h400, 5, 8'hFD);
    chk("bp_no_regrant", pop, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_no_regrant", pop, 8'h00);
      chk("bp_idle_busy", busy, 1'b0);
    end
    ready = 8'hFF;
    #1;
    run_pkt(1, 12'h400, 5, 8'hFF);

    // Reset at the third word of an 8-word WRR packet on queue 2.
    drive(1'b1, 8'h04, 8'hFF, 32'h1111_1311, 7'd8, 12'h000);
    #1;
    chk("rstpkt_pop", pop, 8'h04);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk("rstpkt_rd_request", rd_request, 1'b1);
      chk("rstpkt_rd_addr", rd_addr, 12'h200 + 12'(c - 1));
    end
    rst = 1'b1;
    prepared = 8'h00;
    @(posedge clk); #1;
    chk("midrst_pop", pop, 8'h00);
    chk("midrst_rd_request", rd_request, 1'b0);
    chk("midrst_rd_addr", rd_addr, 12'h000);
    chk("midrst_rd_sop", rd_sop, 1'b0);
    chk("midrst_rd_eop", rd_eop, 1'b0);
    chk("midrst_rd_vld", rd_vld, 1'b0);
    chk("midrst_rd_data", rd_data, 64'h0);
    chk("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("postrst_rd_vld", rd_vld, 1'b0);
      chk("postrst_rd_eop", rd_eop, 1'b0);
    end
    // Pointer back at 0: WRR with queues 1 and 4 eligible must pick 1.
    drive(1'b1, 8'h12, 8'hFF, 32'h1111_1111, 7'd1, 12'h000);
    #1;
    run_pkt(1, 12'h100, 1, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
